return_stack: RTL
=================

Name: return_stack

Overview:
- Hardware LIFO of return addresses that produces the FROM_STACK value consumed by the program-counter select logic.
- The control unit pushes the return PC on CALL and on interrupt entry.
- RET and RETIE pop the stack.
- Top-of-stack is always presented on FROM_STACK so the PC can load it in the same cycle as the pop.

Parameters:
- WIDTH, 10, bit width of each stored address (matches PC width).
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- PTR_W, 3, log2(DEPTH); the count uses PTR_W+1 bits.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  asynchronous reset, active-high.
- PUSH  input  1  push PUSH_DATA this cycle.
- POP  input  1  pop top entry this cycle.
- PUSH_DATA  input  WIDTH  address to store (return PC).
- CLR_ERR  input  1  clears the sticky error flags.
- FROM_STACK  output  WIDTH  current top-of-stack; 0x000 when empty.
- EMPTY  output  1  count == 0.
- FULL  output  1  count == DEPTH.
- COUNT  output  PTR_W+1  number of valid entries.
- OVERFLOW  output  1  sticky; set by a push while full.
- UNDERFLOW  output  1  sticky; set by a pop while empty.

Behaviour:
- Reset (RST high, asynchronous, dominant over all inputs):
  - COUNT=0, OVERFLOW=0, UNDERFLOW=0, EMPTY=1, FULL=0, FROM_STACK=0x000.
  - Array contents need not be cleared.
- Storage and outputs:
  - Storage is a register array mem[0..DEPTH-1]; entry mem[COUNT-1] is top.
  - FROM_STACK is a combinational read of mem[COUNT-1] when COUNT>0, else 0x000. It has no clock latency: the value written by a push is visible the cycle after that push's rising edge.
  - EMPTY and FULL are decoded combinationally from the registered COUNT.
- Cycle behaviour (evaluated at rising CLK):
  - PUSH only, not full: mem[COUNT] <= PUSH_DATA; COUNT <= COUNT+1.
  - PUSH only, full: write discarded; COUNT and contents unchanged; OVERFLOW <= 1.
  - POP only, not empty: COUNT <= COUNT-1. The popped value is the FROM_STACK value presented before the edge; the PC latches it on that same edge.
  - POP only, empty: no change; UNDERFLOW <= 1.
  - PUSH and POP, not empty (including full): replace top, mem[COUNT-1] <= PUSH_DATA; COUNT unchanged; no flags set.
  - PUSH and POP, empty: treated as push; mem[0] <= PUSH_DATA; COUNT <= 1; UNDERFLOW <= 1.
  - Neither: hold.
- Error flags:
  - CLR_ERR clears OVERFLOW and UNDERFLOW.
  - If an error event occurs in the same cycle as CLR_ERR, the set wins and the flag stays 1.
- Width rules:
  - COUNT never exceeds DEPTH and never wraps below 0; pointer arithmetic is saturating by the rules above.
  - PUSH_DATA is stored unmodified; no address increment inside this block.
- Reset mid-operation: an asynchronous RST asserted between edges empties the stack immediately. A push or pop at the next edge while RST is still high has no effect.

Test Plan:
- Reset -> COUNT=0, EMPTY=1, FULL=0, FROM_STACK=0x000, both flags 0. Then push 0x12A -> next cycle COUNT=1, FROM_STACK=0x12A, EMPTY=0.
- Push 0x001..0x008 in consecutive cycles (DEPTH=8) -> FULL=1, FROM_STACK=0x008. A ninth push of 0x3FF -> COUNT stays 8, FROM_STACK=0x008, OVERFLOW=1. Eight pops then yield 0x008,0x007,…,0x001 in order, ending EMPTY=1.
- Pop while empty -> UNDERFLOW=1, COUNT=0, FROM_STACK=0x000. CLR_ERR for one cycle -> UNDERFLOW=0. Pop and CLR_ERR in the same cycle while empty -> UNDERFLOW=1.
- Push 0x050, push 0x060, then PUSH=POP=1 with 0x070 -> COUNT=2, FROM_STACK=0x070. Pop -> FROM_STACK=0x050. PUSH=POP=1 when empty with 0x0AA -> COUNT=1, FROM_STACK=0x0AA, UNDERFLOW=1.
- Full stack, PUSH=POP=1 with 0x3FF -> COUNT=8, FROM_STACK=0x3FF, OVERFLOW stays 0.
- Push three entries, assert RST mid-cycle (between edges) -> COUNT=0, EMPTY=1, FROM_STACK=0x000 before the next edge. Hold PUSH=1 during RST -> COUNT stays 0 until RST deasserts.

Source files
------------

// File: rtl/return_stack_if.sv
// Return-stack control/status bundle between the control unit and the stack.
//   push, pop, push_data, clr_err  : control unit -> stack
//   from_stack, empty, full, count : stack -> PC select / control unit
//   overflow, underflow            : sticky error status
interface return_stack_if #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned PTR_W = 3
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic             clr_err;
  logic [WIDTH-1:0] from_stack;
  logic             empty;
  logic             full;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, push_data, clr_err,
    input  from_stack, empty, full, count, overflow, underflow
  );

  modport slave (
    input  push, pop, push_data, clr_err,
    output from_stack, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/return_stack.sv
// Hardware LIFO of return addresses. The top entry is presented
// combinationally on from_stack so the PC can load it on the same edge
// that pops it.
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active high
//   bus  : return_stack_if.slave (push/pop/push_data/clr_err in,
//          from_stack/empty/full/count/overflow/underflow out)
module return_stack #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  return_stack_if.slave bus
);

  localparam int unsigned CW = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;
  logic             overflow;
  logic             underflow;
  logic             ovf_set;
  logic             unf_set;
  logic             we;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_idx;
  logic             empty_c;
  logic             full_c;

  assign empty_c = (count == CW'(0));
  assign full_c  = (count == CW'(DEPTH));
  // Wraps to all-ones when empty; harmless because the read is gated below.
  assign top_idx = PTR_W'(count - CW'(1));

  // Next count, write strobe and error events for this cycle.
  always_comb begin
    count_n = count;
    we      = 1'b0;
    wr_idx  = top_idx;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case ({bus.push, bus.pop})
      2'b10: begin
        if (full_c) begin
          ovf_set = 1'b1;
        end else begin
          we      = 1'b1;
          wr_idx  = PTR_W'(count);
          count_n = count + CW'(1);
        end
      end
      2'b01: begin
        if (empty_c) begin
          unf_set = 1'b1;
        end else begin
          count_n = count - CW'(1);
        end
      end
      2'b11: begin
        we = 1'b1;
        if (empty_c) begin
          // Nothing to replace: behaves as a push but still flags the pop.
          wr_idx  = '0;
          count_n = CW'(1);
          unf_set = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Count and sticky flags; an error event beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_n;
      overflow  <= ovf_set | (overflow  & ~bus.clr_err);
      underflow <= unf_set | (underflow & ~bus.clr_err);
    end
  end

  // Storage array, not reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem[wr_idx] <= bus.push_data;
    end
  end

  assign bus.from_stack = empty_c ? '0 : mem[top_idx];
  assign bus.empty      = empty_c;
  assign bus.full       = full_c;
  assign bus.count      = count;
  assign bus.overflow   = overflow;
  assign bus.underflow  = underflow;

endmodule
